bistable_ring_ctrl: RTL and testbench
=====================================

# bistable_ring_ctrl

Evaluation controller for the 32-stage bistable ring PUF; sits directly upstream of the ring and consumes its response. It latches a challenge and drives the ring's challenge and reset inputs. Each evaluation resets the ring, lets it settle and samples its response bit through a synchronizer. The result is a majority vote over NUM_EVALS evaluations, delivered with a one-cycle done pulse.

## Interface
- RESET_CYCLES, 8: cycles ring_reset is held high per evaluation; range 1..65535
- SETTLE_CYCLES, 64: cycles after ring_reset release before sampling; range 3..65535
- NUM_EVALS, 7: evaluations per request; odd, range 1..15
- clk  input  1  single clock, all state rising-edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; accepted only when busy=0
- challenge_in  input  32  challenge, sampled on the accepting edge
- ring_rsp  input  1  ring response bit; asynchronous to clk
- ring_challenge  output  32  challenge to ring
- ring_reset  output  1  ring reset, active-high
- busy  output  1  evaluation in progress
- done  output  1  one-cycle pulse, result valid
- response  output  1  majority-voted PUF bit
- ones_count  output  4  number of evaluations that sampled 1

## Operation
- Reset values: ring_challenge=0, ring_reset=1, busy=0, done=0, response=0, ones_count=0, synchronizer flops=0, FSM=IDLE.
- Two-flop synchronizer on ring_rsp; only its output (rsp_sync) is used.
- FSM states:
  - IDLE: ring_reset=1. On start=1: latch challenge_in into ring_challenge, clear eval and ones counters, set busy=1, go to RESET.
  - RESET: ring_reset=1 for exactly RESET_CYCLES cycles, then go to SETTLE.
  - SETTLE: ring_reset=0 for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: ring_reset=0 for 1 cycle. Add rsp_sync to the ones counter.
    - If this is not the last evaluation: increment the eval counter, go to RESET.
    - Else go to IDLE, registering done=1, busy=0, ones_count=final count, and response=(final count > NUM_EVALS/2).
- Phase counter is 16 bits, reloaded on each state entry. Eval counter is 4 bits.
- ring_challenge holds constant from the accepting edge until the next accepted start, including while idle.
- response and ones_count hold their values until the next request completes; they are not cleared by start.
- start while busy=1 is ignored and does not queue.
- ring_rsp is don't-care outside SAMPLE; glitches during RESET/SETTLE have no effect.

## Timing
- Accepting edge E0 is the first edge with IDLE and start=1. busy=1 and ring_reset=1 from E0.
- Each evaluation lasts RESET_CYCLES+SETTLE_CYCLES+1 cycles.
- For evaluation k (k=0..NUM_EVALS-1), with P = RESET_CYCLES+SETTLE_CYCLES+1:
  - ring_reset falls at E0 + k·P + RESET_CYCLES.
  - ring_reset rises at E0 + (k+1)·P.
- done rises and busy falls at E0 + NUM_EVALS·P (defaults: E0+511); done falls one edge later.
- Sampled value reflects ring_rsp at least 2 cycles before the SAMPLE edge; SETTLE_CYCLES≥3 guarantees this is post-release.
- Back-to-back: start=1 during the done=1 cycle is accepted on the next edge (FSM is IDLE); no dead cycle.
- Asynchronous reset mid-operation immediately forces all outputs to reset values, including ring_reset=1. No done is produced and the partial result is discarded.
- start asserted in the same cycle reset_n deasserts is accepted on the first edge after reset release.

## Test plan
- Defaults, ring model ring_rsp=1 constant, challenge_in=32'hA5A5_5A5A -> ring_challenge=A5A55A5A, done at E0+511, ones_count=7, response=1, busy low at same edge.
- Ring model returning 1,0,1,0,1,0,0 per evaluation -> ones_count=3, response=0. Also 1,1,0,1,0,0,1 -> ones_count=4, response=1.
- Waveform check, defaults -> exactly 7 ring_reset high windows of 8 cycles (first starts at E0) separated by 65-cycle low windows, and ring_challenge stable throughout.
- start pulsed with challenge 32'h1234_5678 at E0+100 during busy -> ignored; ring_challenge unchanged, single done at E0+511.
- reset_n low during SETTLE of evaluation 3 -> same cycle ring_reset=1, busy=0, done=0, ones_count=0, response=0. Fresh start afterward completes normally in 511 cycles.
- start held high through done cycle -> second request accepted at E0+512, done again at E0+1023, with no missed or duplicated done pulses.

Source files
------------

// File: rtl/bistable_ring_ctrl.sv
// Evaluation controller for a 32-stage bistable ring PUF: resets the ring, lets it
// settle, samples its synchronized response and majority-votes NUM_EVALS evaluations.
module bistable_ring_ctrl #(
    parameter int unsigned RESET_CYCLES  = 8,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned NUM_EVALS     = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] challenge_in,
    input  logic        ring_rsp,
    output logic [31:0] ring_challenge,
    output logic        ring_reset,
    output logic        busy,
    output logic        done,
    output logic        response,
    output logic [3:0]  ones_count
);

    localparam int unsigned PHASE_W = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CHAL_W  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESET  = 2'd1,
        SETTLE = 2'd2,
        SAMPLE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0]    eval_q, eval_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic                rr_q, rr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                resp_q, resp_d;
    logic [1:0]          sync_q;

    logic                rsp_sync;
    logic                last_eval;
    logic [CNT_W-1:0]    acc_sum;

    assign rsp_sync  = sync_q[1];
    assign last_eval = (eval_q == CNT_W'(NUM_EVALS - 1));
    assign acc_sum   = acc_q + CNT_W'(rsp_sync);

    // Two-flop synchronizer; ring_rsp is asynchronous to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], ring_rsp};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RESET;
            RESET:   if (phase_q == '0) state_d = SETTLE;
            SETTLE:  if (phase_q == '0) state_d = SAMPLE;
            SAMPLE:  state_d = last_eval ? IDLE : RESET;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        phase_d = phase_q;
        eval_d  = eval_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        chal_d  = chal_q;
        resp_d  = resp_q;
        done_d  = 1'b0;
        rr_d    = (state_d == IDLE) || (state_d == RESET);
        busy_d  = (state_d != IDLE);

        if (state_q != IDLE) begin
            phase_d = phase_q - PHASE_W'(1);
        end
        // Phase counter reloads on every state entry
        if (state_d != state_q) begin
            phase_d = (state_d == SETTLE) ? PHASE_W'(SETTLE_CYCLES - 1)
                                          : PHASE_W'(RESET_CYCLES - 1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d = challenge_in;
                    eval_d = '0;
                    acc_d  = '0;
                end
            end
            SAMPLE: begin
                acc_d = acc_sum;
                if (last_eval) begin
                    done_d = 1'b1;
                    cnt_d  = acc_sum;
                    resp_d = (acc_sum > CNT_W'(NUM_EVALS / 2));
                end else begin
                    eval_d = eval_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            eval_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            chal_q  <= '0;
            rr_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            eval_q  <= eval_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            chal_q  <= chal_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
        end
    end

    assign ring_challenge = chal_q;
    assign ring_reset     = rr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign response       = resp_q;
    assign ones_count     = cnt_q;

endmodule

// File: tb/tb_bistable_ring_ctrl.sv
// Self-checking bench for bistable_ring_ctrl: table vectors, random patterns,
// abort by reset, ignored start and back-to-back requests.
module tb_bistable_ring_ctrl;

    localparam int R     = 8;
    localparam int S     = 64;
    localparam int N     = 7;
    localparam int P     = R + S + 1;
    localparam int TOTAL = N * P;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] challenge_in;
    logic        ring_rsp;
    logic [31:0] ring_challenge;
    logic        ring_reset;
    logic        busy;
    logic        done;
    logic        response;
    logic [3:0]  ones_count;

    bistable_ring_ctrl #(
        .RESET_CYCLES (R),
        .SETTLE_CYCLES(S),
        .NUM_EVALS    (N)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .challenge_in  (challenge_in),
        .ring_rsp      (ring_rsp),
        .ring_challenge(ring_challenge),
        .ring_reset    (ring_reset),
        .busy          (busy),
        .done          (done),
        .response      (response),
        .ones_count    (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [3:0] prev_ones = '0;
    logic       prev_resp = 1'b0;

    typedef struct {
        logic [6:0]  pat;
        logic [31:0] chal;
        logic [3:0]  exp_ones;
        logic        exp_resp;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Ring reset is high for the first R cycles of each P-cycle evaluation, and while idle
    function automatic logic exp_rr(input int t);
        return (t >= TOTAL) || ((t % P) < R);
    endfunction

    // Present a request on the next edge
    task automatic begin_req(input logic [31:0] chal);
        start        = 1'b1;
        challenge_in = chal;
    endtask

    // Follow one request from its accepting edge E0; acts as the ring model too
    task automatic track(input logic [6:0] pat, input logic [31:0] chal,
                         input logic [3:0] exp_ones, input logic exp_resp,
                         input bit keep_start, input int inject_at, input int abort_at);
        int done_t = -1;
        int rr_err = 0;
        int ch_err = 0;
        bit aborted = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        check("busy_at_e0", 32'(busy), 32'd1);
        check("done_low_e0", 32'(done), 32'd0);
        check("ones_held", 32'(ones_count), 32'(prev_ones));
        check("resp_held", 32'(response), 32'(prev_resp));
        for (int t = 0; t <= TOTAL + 20; t++) begin
            if (t > 0) @(negedge clk);
            if (ring_reset !== exp_rr(t)) rr_err++;
            if (ring_challenge !== chal) ch_err++;
            ring_rsp = ring_reset ? 1'($urandom) : pat[3'(t / P)];
            if (t == inject_at) begin
                start        = 1'b1;
                challenge_in = 32'h1234_5678;
            end
            if (t == inject_at + 1) begin
                start        = 1'b0;
                challenge_in = chal;
            end
            if (t == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (done === 1'b1) begin
                done_t = t;
                break;
            end
        end
        check("rr_wave", 32'(rr_err), 32'd0);
        check("chal_stable", 32'(ch_err), 32'd0);
        if (!aborted) begin
            check("done_latency", 32'(done_t), 32'(TOTAL));
            check("busy_low_at_done", 32'(busy), 32'd0);
            check("ones_count", 32'(ones_count), 32'(exp_ones));
            check("response", 32'(response), 32'(exp_resp));
            prev_ones = exp_ones;
            prev_resp = exp_resp;
            if (!keep_start) begin
                @(negedge clk);
                check("done_fall", 32'(done), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        logic [6:0] rp;
        logic [31:0] rc;
        int ones;

        vecs[0] = '{7'b1111111, 32'hA5A5_5A5A, 4'd7, 1'b1};
        vecs[1] = '{7'b0010101, 32'hDEAD_BEEF, 4'd3, 1'b0};
        vecs[2] = '{7'b1001011, 32'h0F0F_00FF, 4'd4, 1'b1};
        vecs[3] = '{7'b0000000, 32'hFFFF_FFFF, 4'd0, 1'b0};

        reset_n      = 1'b0;
        start        = 1'b0;
        challenge_in = '0;
        ring_rsp     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ring_reset", 32'(ring_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_chal", ring_challenge, 32'd0);
        check("rst_ones", 32'(ones_count), 32'd0);
        check("rst_resp", 32'(response), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors
        for (int i = 0; i < 4; i++) begin
            begin_req(vecs[i].chal);
            track(vecs[i].pat, vecs[i].chal, vecs[i].exp_ones, vecs[i].exp_resp, 1'b0, -10, -10);
        end

        // Ignored start during busy
        begin_req(32'hCAFE_0001);
        track(7'b1001011, 32'hCAFE_0001, 4'd4, 1'b1, 1'b0, 100, -10);
        repeat (600) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("no_extra_done", 32'(done), 32'd0);

        // Reset during SETTLE of evaluation 3
        begin_req(32'h5555_AAAA);
        track(7'b1111111, 32'h5555_AAAA, 4'd7, 1'b1, 1'b0, -10, 3 * P + R + 20);
        reset_n = 1'b0;
        #1;
        check("abort_ring_reset", 32'(ring_reset), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ones", 32'(ones_count), 32'd0);
        check("abort_resp", 32'(response), 32'd0);
        check("abort_chal", ring_challenge, 32'd0);
        prev_ones = '0;
        prev_resp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        begin_req(32'h0BAD_F00D);
        track(7'b0111101, 32'h0BAD_F00D, 4'd5, 1'b1, 1'b0, -10, -10);

        // Start held through done: back-to-back requests
        begin_req(32'h1357_9BDF);
        track(7'b1100000, 32'h1357_9BDF, 4'd2, 1'b0, 1'b1, -10, -10);
        track(7'b1100000, 32'h1357_9BDF, 4'd2, 1'b0, 1'b0, -10, -10);

        // Random patterns against a popcount/majority model
        for (int i = 0; i < 4; i++) begin
            rp   = 7'($urandom);
            rc   = $urandom;
            ones = $countones(rp);
            begin_req(rc);
            track(rp, rc, 4'(ones), (ones > N / 2), 1'b0, -10, -10);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
